// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 mouse sequencer types and constants.
// Revision: 1.0
`default_nettype none

package ps2_pkg;

   typedef enum logic [2:0] {
      ST_SEND     = 3'd0,
      ST_WAIT_TX  = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_B1       = 3'd3,
      ST_B2       = 3'd4,
      ST_B3       = 3'd5,
      ST_ERR      = 3'd6
   } ps2_state_t;

   localparam logic [7:0] PS2_CMD_STREAM_EN = 8'hF4;
   localparam logic [7:0] PS2_ACK           = 8'hFA;

   // Bit positions inside the first packet byte
   localparam int PS2_B1_SYNC = 3;
   localparam int PS2_B1_XS   = 4;
   localparam int PS2_B1_YS   = 5;

endpackage

`default_nettype wire

// File: rtl/ps2_mouse_ctrl_if.sv
// ps2_mouse_ctrl_if: byte receiver/transmitter handshake and mouse packet outputs.
// Revision: 1.0
`default_nettype none

interface ps2_mouse_ctrl_if;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       tx_done_tick;
   logic       rx_en;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [8:0] xm;
   logic [8:0] ym;
   logic [2:0] btnm;
   logic       m_done_tick;
   logic       init_done;
   logic       err;

   modport master (
      input  rx_done_tick, rx_data, tx_done_tick,
      output rx_en, tx_start, tx_data, xm, ym, btnm, m_done_tick, init_done, err
   );

   modport slave (
      output rx_done_tick, rx_data, tx_done_tick,
      input  rx_en, tx_start, tx_data, xm, ym, btnm, m_done_tick, init_done, err
   );
endinterface

`default_nettype wire

// File: rtl/ps2_mouse_pkt.sv
// ps2_mouse_pkt: byte1/byte2 latches and registered packet outputs.
// Revision: 1.0
`default_nettype none

module ps2_mouse_pkt (
   input  logic       clk,
   input  logic       reset,
   input  logic       latch1,
   input  logic       latch2,
   input  logic       load,
   input  logic [4:0] hdr,      // {ys, xs, btn[2:0]} of the current byte
   input  logic [7:0] rx_data,
   output logic [8:0] xm,
   output logic [8:0] ym,
   output logic [2:0] btnm,
   output logic       m_done_tick
);

   logic [4:0] byte1_hdr;
   logic [7:0] byte2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte1_hdr   <= '0;
         byte2       <= '0;
         xm          <= '0;
         ym          <= '0;
         btnm        <= '0;
         m_done_tick <= 1'b0;
      end else begin
         m_done_tick <= load;
         if (latch1) byte1_hdr <= hdr;
         if (latch2) byte2     <= rx_data;
         if (load) begin
            xm   <= {byte1_hdr[3], byte2};
            ym   <= {byte1_hdr[4], rx_data};
            btnm <= byte1_hdr[2:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse init (stream enable + ACK) and 3-byte packet sequencer.
// Optional watchdog enabled by defining PS2_MOUSE_TIMEOUT_EN. Revision: 1.0
`default_nettype none

module ps2_mouse_ctrl
   import ps2_pkg::*;
#(
   parameter logic [7:0] CMD            = PS2_CMD_STREAM_EN,
   parameter logic [7:0] ACK            = PS2_ACK,
   parameter int         MAX_RETRY      = 3,
   parameter int         TIMEOUT_CYCLES = 2_000_000
) (
   input  logic              clk,
   input  logic              reset,
   ps2_mouse_ctrl_if.master  bus
);

   localparam int RW = $clog2(MAX_RETRY + 2);

   ps2_state_t    state;
   logic [RW-1:0] retry_cnt;
   logic          rx_en;
   logic          tx_start;
   logic          init_done;
   logic          err;
   logic          tmo;
   logic          retry_ok;

   assign retry_ok = (retry_cnt < RW'(MAX_RETRY));

`ifdef PS2_MOUSE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt;
   logic          timed;
   logic          leaving;

   assign timed = (state == ST_WAIT_TX) || (state == ST_WAIT_ACK) ||
                  (state == ST_B2)      || (state == ST_B3);
   assign tmo   = timed && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   // Every exit from a timed state is one of these events
   assign leaving = tmo || ((state == ST_WAIT_TX) ? bus.tx_done_tick : bus.rx_done_tick);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  tmo_cnt <= '0;
      else if (!timed || leaving) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_SEND;
         retry_cnt <= '0;
         rx_en     <= 1'b0;
         tx_start  <= 1'b0;
         init_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_SEND: begin
               tx_start <= 1'b1;
               rx_en    <= 1'b0;
               state    <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (bus.tx_done_tick) begin
                  rx_en <= 1'b1;
                  state <= ST_WAIT_ACK;
               end else if (tmo) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= retry_ok ? ST_SEND : ST_ERR;
                  err       <= !retry_ok;
               end
            end
            ST_WAIT_ACK: begin
               if (bus.rx_done_tick && bus.rx_data == ACK) begin
                  init_done <= 1'b1;
                  state     <= ST_B1;
               end else if (bus.rx_done_tick || tmo) begin
                  rx_en     <= 1'b0;
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= retry_ok ? ST_SEND : ST_ERR;
                  err       <= !retry_ok;
               end
            end
            ST_B1: begin
               // Bytes without the sync bit are dropped to regain packet alignment
               if (bus.rx_done_tick && bus.rx_data[PS2_B1_SYNC]) state <= ST_B2;
            end
            ST_B2: begin
               if (bus.rx_done_tick)  state <= ST_B3;
               else if (tmo)          state <= ST_B1;
            end
            ST_B3: begin
               if (bus.rx_done_tick || tmo) state <= ST_B1;
            end
            ST_ERR: begin
               rx_en <= 1'b0;
               err   <= 1'b1;
            end
            default: state <= ST_SEND;
         endcase
      end
   end

   logic latch1;
   logic latch2;
   logic load;

   assign latch1 = (state == ST_B1) && bus.rx_done_tick && bus.rx_data[PS2_B1_SYNC];
   assign latch2 = (state == ST_B2) && bus.rx_done_tick;
   assign load   = (state == ST_B3) && bus.rx_done_tick;

   ps2_mouse_pkt u_pkt (
      .clk         (clk),
      .reset       (reset),
      .latch1      (latch1),
      .latch2      (latch2),
      .load        (load),
      .hdr         ({bus.rx_data[PS2_B1_YS], bus.rx_data[PS2_B1_XS], bus.rx_data[2:0]}),
      .rx_data     (bus.rx_data),
      .xm          (bus.xm),
      .ym          (bus.ym),
      .btnm        (bus.btnm),
      .m_done_tick (bus.m_done_tick)
   );

   assign bus.rx_en     = rx_en;
   assign bus.tx_start  = tx_start;
   assign bus.tx_data   = CMD;
   assign bus.init_done = init_done;
   assign bus.err       = err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl: randomized self-checking bench with a packet-level reference model.
// Revision: 1.0
`default_nettype none

module tb_ps2_mouse_ctrl;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ps2_mouse_ctrl_if bus ();

   ps2_mouse_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int tx_count = 0;

   // Reference model: bytes of the packet being assembled and the last packet seen
   logic [7:0] pend[$];
   logic [8:0] exp_xm;
   logic [8:0] exp_ym;
   logic [2:0] exp_btn;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (bus.tx_start === 1'b1) tx_count++;

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.rx_done_tick = 1'b0;
      bus.tx_done_tick = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_rx_en",     bus.rx_en, 0);
      check_eq("rst_tx_start",  bus.tx_start, 0);
      check_eq("rst_tx_data",   bus.tx_data, 8'hF4);
      check_eq("rst_xm",        bus.xm, 0);
      check_eq("rst_ym",        bus.ym, 0);
      check_eq("rst_btnm",      bus.btnm, 0);
      check_eq("rst_m_done",    bus.m_done_tick, 0);
      check_eq("rst_init_done", bus.init_done, 0);
      check_eq("rst_err",       bus.err, 0);
      tx_count = 0;
      pend.delete();
      exp_xm  = '0;
      exp_ym  = '0;
      exp_btn = '0;
      reset = 1'b0;
   endtask

   task automatic wait_tx_start(input string tag);
      int k = 0;
      @(negedge clk);
      while (bus.tx_start !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq(tag, bus.tx_start, 1);
      check_eq("tx_data", bus.tx_data, 8'hF4);
      check_eq("rx_en_during_tx", bus.rx_en, 0);
      @(negedge clk);
      check_eq("tx_start_one_cycle", bus.tx_start, 0);
      check_eq("rx_en_wait_tx", bus.rx_en, 0);
   endtask

   task automatic pulse_tx_done();
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = b;
      @(negedge clk);
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'($urandom);
   endtask

   task automatic do_init();
      apply_reset();
      wait_tx_start("tx_start_init");
      send_rx(8'hFA);
      check_eq("stray_rx_init_done", bus.init_done, 0);
      check_eq("stray_rx_rx_en", bus.rx_en, 0);
      pulse_tx_done();
      check_eq("rx_en_after_tx_done", bus.rx_en, 1);
      check_eq("init_done_before_ack", bus.init_done, 0);
      send_rx(8'hFA);
      check_eq("init_done_after_ack", bus.init_done, 1);
      check_eq("tx_count_init", tx_count, 1);
   endtask

   task automatic feed(input logic [7:0] b);
      logic done = 1'b0;
      int   dx;
      int   dy;
      if (pend.size() != 0 || b[3]) pend.push_back(b);
      if (pend.size() == 3) begin
         dx = int'(pend[1]) - (pend[0][4] ? 256 : 0);
         dy = int'(pend[2]) - (pend[0][5] ? 256 : 0);
         exp_xm  = dx[8:0];
         exp_ym  = dy[8:0];
         exp_btn = pend[0][2:0];
         done    = 1'b1;
         pend.delete();
      end
      send_rx(b);
      check_eq("m_done_tick", bus.m_done_tick, done);
      check_eq("xm", bus.xm, exp_xm);
      check_eq("ym", bus.ym, exp_ym);
      check_eq("btnm", bus.btnm, exp_btn);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tx_done_tick = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         bus.tx_done_tick = 1'b0;
         check_eq("idle_m_done", bus.m_done_tick, 0);
         check_eq("idle_xm_hold", bus.xm, exp_xm);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus.rx_done_tick = 1'b0;
      bus.tx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;

      do_init();
      feed(8'h19); feed(8'h05); feed(8'hFE);
      gap(2);
      feed(8'h00); feed(8'h08); feed(8'h10); feed(8'h20);
      gap(1);
      for (int i = 0; i < 300; i++) begin
         feed(8'($urandom));
         gap($urandom_range(0, 2));
      end
      check_eq("init_done_hold", bus.init_done, 1);
      check_eq("err_clear", bus.err, 0);

      // Non-ACK replies exhaust the retries
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         wait_tx_start("tx_start_retry");
         pulse_tx_done();
         check_eq("err_before_final", bus.err, 0);
         send_rx(8'hFE);
      end
      check_eq("err_set", bus.err, 1);
      check_eq("err_rx_en", bus.rx_en, 0);
      check_eq("err_init_done", bus.init_done, 0);
      repeat (5) @(negedge clk);
      check_eq("retry_tx_count", tx_count, 4);
      check_eq("err_sticky", bus.err, 1);

      // Reset between byte2 and byte3 aborts the packet
      do_init();
      feed(8'h08); feed(8'h10);
      apply_reset();
      wait_tx_start("tx_start_after_abort");
      check_eq("abort_no_m_done", bus.m_done_tick, 0);
      check_eq("abort_init_done", bus.init_done, 0);
      pulse_tx_done();
      send_rx(8'hFA);
      check_eq("reinit_done", bus.init_done, 1);
      feed(8'h08); feed(8'h01); feed(8'h02);
      check_eq("reinit_xm", bus.xm, 9'd1);
      check_eq("reinit_ym", bus.ym, 9'd2);

`ifdef PS2_MOUSE_TIMEOUT_EN
      feed(8'h18); feed(8'h33);
      repeat (110) @(negedge clk);
      pend.delete();
      feed(8'h08); feed(8'h01); feed(8'h02);
      check_eq("timeout_xm", bus.xm, 9'd1);
      check_eq("timeout_ym", bus.ym, 9'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
